// File: rtl/mult_pkg.sv
// Shared constants, FSM state type and operand magnitude helper for the
// sequential signed 6x6 multiplier.
package mult_pkg;

  localparam int W  = 6;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // |-32| = 6'b100000 is a valid unsigned magnitude, so no saturation is needed
  function automatic logic [W-1:0] abs_w(input logic signed [W-1:0] v);
    logic [W-1:0] mag;
    mag = v[W-1] ? W'(-v) : W'(v);
    return mag;
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-and-add datapath: multiplicand shifts left, multiplier shifts right,
// accumulator adds the multiplicand whenever the multiplier LSB is set.
module mult_shift_add_dp
  import mult_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          calc,
  input  logic [W-1:0]  a_mag,
  input  logic [W-1:0]  b_mag,
  output logic [PW-1:0] acc
);

  logic [PW-1:0] mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load) begin
      mcand_d  = {{(PW-W){1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
    end else if (calc) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/multiplicador_6bits.sv
// Free-running signed 6x6 multiplier with sign-magnitude result, 8-cycle frame.
// Optional `done` pulse output when MULT_DONE_EN is defined.
module multiplicador_6bits
  import mult_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic [PW-1:0] c,
  output logic          neg
`ifdef MULT_DONE_EN
  ,
  output logic          done
`endif
);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [PW-1:0]  c_q, c_d;
  logic           neg_q, neg_d;
  logic           load, calc;
  logic [PW-1:0]  acc;

  mult_shift_add_dp u_dp (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .calc  (calc),
    .a_mag (abs_w($signed(A))),
    .b_mag (abs_w($signed(B))),
    .acc   (acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    c_d     = c_q;
    neg_d   = neg_q;
    load    = 1'b0;
    calc    = 1'b0;
    case (state_q)
      LOAD: begin
        load    = 1'b1;
        sign_d  = A[W-1] ^ B[W-1];
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        calc  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        c_d     = acc;
        // a zero product is never reported as negative
        neg_d   = sign_q & (|acc);
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      c_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      neg_q   <= neg_d;
    end
  end

  assign c   = c_q;
  assign neg = neg_q;

`ifdef MULT_DONE_EN
  logic done_q, done_d;

  always_comb begin
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_multiplicador_6bits.sv
// Directed self-checking bench for multiplicador_6bits; covers the done pulse
// when built with MULT_DONE_EN.
module tb_multiplicador_6bits;

  logic        clk;
  logic        rst;
  logic [5:0]  A;
  logic [5:0]  B;
  logic [11:0] c;
  logic        neg;
`ifdef MULT_DONE_EN
  logic        done;
`endif

  int checks   = 0;
  int failures = 0;

  multiplicador_6bits dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .c   (c),
    .neg (neg)
`ifdef MULT_DONE_EN
    ,
    .done(done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A, B, |A*B|, sign
  int va [8] = '{ 40, -32, -32,  0, -1, 31,  31, -7};
  int vb [8] = '{  5, -32,   1, -5, -1, 31, -32,  0};
  int vc [8] = '{120, 1024, 32,  0,  1, 961, 992, 0};
  int vn [8] = '{  1,   0,   1,  0,  0,  0,   1,  0};

  initial begin
    rst = 1'b0;
    A   = 6'd9;
    B   = 6'b111001;

    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_val($sformatf("rst_c_%0d", i), int'(c), 0);
      check_val($sformatf("rst_neg_%0d", i), int'(neg), 0);
    end
`ifdef MULT_DONE_EN
    check_val("rst_done", int'(done), 0);
`endif

    rst = 1'b1;
    tick(7);
    check_val("lat_pre_c", int'(c), 0);
    tick(1);
    check_val("lat_c", int'(c), 63);
    check_val("lat_neg", int'(neg), 1);
`ifdef MULT_DONE_EN
    check_val("done_hi", int'(done), 1);
    tick(1);
    check_val("done_lo", int'(done), 0);
    tick(2);
`else
    tick(3);
`endif

    // three cycles into the next frame: asynchronous clear mid-CALC
    rst = 1'b0;
    #1;
    check_val("midrst_c", int'(c), 0);
    check_val("midrst_neg", int'(neg), 0);
    tick(2);
    check_val("midrst_hold_c", int'(c), 0);
    rst = 1'b1;

    // operands captured at first LOAD, then changed during CALC
    tick(2);
    A = 6'd5;
    B = 6'd5;
    tick(6);
    check_val("ignore_c", int'(c), 63);
    check_val("ignore_neg", int'(neg), 1);
`ifdef MULT_DONE_EN
    check_val("done_hi2", int'(done), 1);
`endif
    tick(7);
    check_val("hold_c", int'(c), 63);
`ifdef MULT_DONE_EN
    check_val("done_lo2", int'(done), 0);
`endif
    tick(1);
    check_val("next_c", int'(c), 25);
    check_val("next_neg", int'(neg), 0);
`ifdef MULT_DONE_EN
    check_val("done_hi3", int'(done), 1);
`endif

    for (int i = 0; i < 8; i++) begin
      A = 6'(va[i]);
      B = 6'(vb[i]);
      tick(16);
      check_val($sformatf("vec%0d_c", i), int'(c), vc[i]);
      check_val($sformatf("vec%0d_neg", i), int'(neg), vn[i]);
      if (i == 0) begin
        for (int k = 0; k < 8; k++) begin
          tick(1);
          check_val($sformatf("stable%0d_c", k), int'(c), vc[0]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
